hamming_enc_engine: RTL and testbench
=====================================

// Module: hamming_enc_engine
// PURPOSE
//   Hardware engine for program 1: SECDED Hamming encoder, the inverse of the program-2 decoder.
//   Walks NUM_MSG 11-bit messages in data memory. For each message it inserts parity bits p8/p4/p2/p1
//   and the overall parity bit p0, then writes the 16-bit codeword back to memory.
//   Sits beside the core, owns the dm port while busy, and uses the same start/done handshake as top_level.
// PARAMETERS
//   NUM_MSG   15  messages per run
//   SRC_BASE  0   byte address of message 0 (lo byte; hi byte at +1)
//   DST_BASE  30  byte address of codeword 0 (lo byte; hi byte at +1)
//   ADDR_W    8   data-memory byte-address width
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-high
//   start        in   1       run request; sampled in IDLE or DONE only
//   done         out  1       high while in DONE
//   mem_addr     out  ADDR_W  byte address to dm
//   mem_wr_en    out  1       write strobe, one cycle per byte
//   mem_wr_data  out  8       write byte
//   mem_rd_data  in   8       combinational read data for mem_addr (same cycle)
// BEHAVIOUR
//   Reset, asynchronous: state=IDLE, idx=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, lo/cw regs=0.
//   Message i, 11 bits: d[8:1] = byte[SRC_BASE+2i], d[11:9] = byte[SRC_BASE+2i+1][2:0]; hi bits [7:3] ignored.
//   Parity:
//     p8 = ^d[11:5]
//     p4 = ^d[11:8] ^ ^d[4:2]
//     p2 = d11^d10^d7^d6^d4^d3^d1
//     p1 = d11^d9^d7^d5^d4^d2^d1
//     p0 = ^d ^ p8^p4^p2^p1
//   Codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
//   Output bytes: cw[7:0] to DST_BASE+2i, cw[15:8] to DST_BASE+2i+1.
//   FSM (one state per cycle):
//     IDLE   start=1 -> RD_LO, idx=0
//     RD_LO  addr=SRC+2i, capture lo byte -> RD_HI
//     RD_HI  addr=SRC+2i+1, register cw from {rd[2:0], lo} -> WR_LO
//     WR_LO  addr=DST+2i, wr_en=1, data=cw[7:0] -> WR_HI
//     WR_HI  addr=DST+2i+1, wr_en=1, data=cw[15:8]
//            -> idx==NUM_MSG-1 ? DONE : RD_LO with idx+1
//     DONE   done=1, held; start=1 -> RD_LO, idx=0, done drops on the same edge
//   Timing:
//     - Exactly 4 cycles per message.
//     - done rises 4*NUM_MSG edges after the edge that samples start (60 at default).
//     - mem_wr_en is never high outside WR_LO/WR_HI.
//     - Addresses wrap mod 2^ADDR_W, no error reported.
//   Edge cases:
//     - start while busy is ignored; start held high in DONE restarts every run.
//     - Reset mid-run aborts to IDLE. Bytes already written stay written; no rollback.
//     - Overlapping SRC/DST ranges are legal; a message is read fully before its bytes are written.
// STRUCTURE
//   hamming_pkg:
//     - enum enc_state_t {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE}
//     - NUM_MSG / SRC_BASE / DST_BASE defaults
//     - function hamming_encode(logic [11:1]) -> logic [15:0], shared with the decoder bench model.
//   Sub-module hamming_enc_core: combinational 11 -> 16 encoder, instantiated once.
//   Top holds the FSM, the idx counter, the lo-byte register and the cw register.
// TESTING
//   1. Reset mid-run, at the 3rd message -> all outputs 0 next cycle; message 3+ dst bytes untouched.
//   2. msg 11'h000 -> dst bytes 8'h00, 8'h00.
//      msg 11'h7FF -> 8'hFF, 8'hFF.
//      msg 11'h001 -> 8'h0F, 8'h00.
//   3. hi byte 8'hF8, lo byte 8'h00 -> codeword 16'h0000 (upper input bits ignored).
//   4. 15 random messages, one start pulse:
//      - done rises exactly 60 cycles after start is sampled;
//      - every codeword equals hamming_encode();
//      - exactly 30 write strobes, all in 30..59.
//   5. Round trip: run encoder, flip one random bit per word, run program 2
//      -> every word decodes to {5'b01000, d}.
//   6. start pulsed again mid-run -> ignored; start in DONE -> full second run, 60 cycles.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared state encoding, default geometry and the SECDED
// encode function used by the engine and by the decoder bench model.
package hamming_pkg;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} enc_state_t;

    localparam int DEF_NUM_MSG  = 15;
    localparam int DEF_SRC_BASE = 0;
    localparam int DEF_DST_BASE = 30;
    localparam int DEF_ADDR_W   = 8;

    // Parity bits sit at the power-of-two positions, p0 covers the whole word.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^d[11:8] ^ ^d[4:2];
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// hamming_enc_core: combinational 11-bit message to 16-bit SECDED codeword.
module hamming_enc_core
    import hamming_pkg::*;
(
    input  logic [11:1] data,
    output logic [15:0] cw
);

    always_comb cw = hamming_encode(data);

endmodule

// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine: walks NUM_MSG messages in data memory, encodes each one
// and writes the codeword back, four cycles per message.
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = DEF_NUM_MSG,
    parameter int SRC_BASE = DEF_SRC_BASE,
    parameter int DST_BASE = DEF_DST_BASE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data
);

    localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    enc_state_t        state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        lo;
    logic [15:0]       cw, cw_nx;
    logic [ADDR_W-1:0] off, src, dst;
    logic              last, go;

    hamming_enc_core u_core (
        .data ({mem_rd_data[2:0], lo}),
        .cw   (cw_nx)
    );

    assign last = idx == IDX_W'(NUM_MSG - 1);
    assign go   = (state == IDLE || state == DONE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            lo    <= '0;
            cw    <= '0;
        end else begin
            state <= state_nx;
            if (go)
                idx <= '0;
            else if (state == WR_HI)
                idx <= idx + IDX_W'(1);
            if (state == RD_LO)
                lo <= mem_rd_data;
            if (state == RD_HI)
                cw <= cw_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RD_LO : state;
            RD_LO:      state_nx = RD_HI;
            RD_HI:      state_nx = WR_LO;
            WR_LO:      state_nx = WR_HI;
            WR_HI:      state_nx = last ? DONE : RD_LO;
            default:    state_nx = IDLE;
        endcase
    end

    // Byte offsets wrap modulo 2^ADDR_W by construction of the casts.
    always_comb begin
        off         = ADDR_W'({idx, 1'b0});
        src         = ADDR_W'(SRC_BASE) + off;
        dst         = ADDR_W'(DST_BASE) + off;
        mem_addr    = state == RD_LO ? src :
                      state == RD_HI ? src + ADDR_W'(1) :
                      state == WR_LO ? dst :
                      state == WR_HI ? dst + ADDR_W'(1) : '0;
        mem_wr_en   = state == WR_LO || state == WR_HI;
        mem_wr_data = state == WR_LO ? cw[7:0] :
                      state == WR_HI ? cw[15:8] : '0;
        done        = state == DONE;
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb_hamming_enc_engine: directed table vectors plus reset, restart and
// round-trip sequences against a byte-wide memory model.
module tb_hamming_enc_engine;

    logic       clk = 0, reset = 1, start = 0;
    logic       done, mem_wr_en;
    logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
    logic       tb_we = 0;
    logic [7:0] tb_a = 0, tb_d = 0;
    logic [7:0] mem [256];
    int         strobes = 0, bad_addr = 0;
    int         n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [7:0] lo, hi, elo, ehi;
    } vec_t;
    vec_t tv [8];
    logic [7:0] srcb [30];

    hamming_enc_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_a] <= tb_d;
        else if (mem_wr_en)
            mem[mem_addr] <= mem_wr_data;
        if (mem_wr_en) begin
            strobes <= strobes + 1;
            if (mem_addr < 30 || mem_addr > 59)
                bad_addr <= bad_addr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1;
        tb_a  = a;
        tb_d  = d;
        @(posedge clk);
        #1 tb_we = 0;
    endtask

    // Returns edges from the start-sampling edge until done is seen high.
    task automatic run(input int pulse_at, output int cycles);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        check("done_drop", 32'(done), 0);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1 cycles++;
            start = (cycles == pulse_at);
        end
        start = 0;
    endtask

    // Independent model: place data at non-power-of-two positions, parity from syndrome.
    function automatic logic [15:0] ref_enc(input logic [11:1] d);
        logic [15:0] c = '0;
        logic [3:0]  s = '0;
        int          k = 1;
        for (int j = 1; j < 16; j++)
            if ((j & (j - 1)) != 0) begin
                c[j] = d[k];
                if (d[k]) s ^= 4'(j);
                k++;
            end
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c[15:1];
        return c;
    endfunction

    initial begin
        int cyc, s0, b0;
        tv[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        tv[1] = '{8'hFF, 8'h07, 8'hFF, 8'hFF};
        tv[2] = '{8'h01, 8'h00, 8'h0F, 8'h00};
        tv[3] = '{8'h00, 8'hF8, 8'h00, 8'h00};
        tv[4] = '{8'h00, 8'h04, 8'h17, 8'h81};
        tv[5] = '{8'h02, 8'h00, 8'h33, 8'h00};
        tv[6] = '{8'h10, 8'h00, 8'h03, 8'h03};
        tv[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wr_data", 32'(mem_wr_data), 0);
        @(negedge clk) reset = 0;

        for (int i = 0; i < 15; i++) begin
            poke(8'(2 * i), i < 8 ? tv[i].lo : 8'h00);
            poke(8'(2 * i + 1), i < 8 ? tv[i].hi : 8'h00);
            poke(8'(30 + 2 * i), 8'hA5);
            poke(8'(31 + 2 * i), 8'hA5);
        end
        s0 = strobes;
        b0 = bad_addr;
        run(-1, cyc);
        check("table_cycles", 32'(cyc), 60);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tv%0d_lo", i), 32'(mem[30 + 2 * i]), 32'(tv[i].elo));
            check($sformatf("tv%0d_hi", i), 32'(mem[31 + 2 * i]), 32'(tv[i].ehi));
        end
        check("zero_msg_tail", 32'({mem[58], mem[59]}), 0);
        check("table_strobes", 32'(strobes - s0), 30);
        check("table_bad_addr", 32'(bad_addr - b0), 0);
        repeat (3) @(posedge clk);
        #1 check("done_held", 32'(done), 1);

        for (int i = 30; i < 60; i++)
            poke(8'(i), 8'hA5);
        @(negedge clk) start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (8) @(posedge clk);
        #1 reset = 1;
        #1;
        check("midrst_wr_en", 32'(mem_wr_en), 0);
        check("midrst_addr", 32'(mem_addr), 0);
        @(posedge clk);
        #1;
        check("midrst_done", 32'(done), 0);
        check("midrst_wr_data", 32'(mem_wr_data), 0);
        @(negedge clk) reset = 0;
        check("midrst_m0", 32'({mem[31], mem[30]}), 32'({tv[0].ehi, tv[0].elo}));
        check("midrst_m1", 32'({mem[33], mem[32]}), 32'({tv[1].ehi, tv[1].elo}));
        begin
            int untouched = 0;
            for (int i = 34; i < 60; i++)
                if (mem[i] === 8'hA5) untouched++;
            check("midrst_untouched", 32'(untouched), 26);
        end

        for (int i = 0; i < 30; i++) begin
            srcb[i] = 8'($urandom);
            poke(8'(i), srcb[i]);
        end
        s0 = strobes;
        b0 = bad_addr;
        run(10, cyc);
        check("rand_cycles", 32'(cyc), 60);
        check("rand_strobes", 32'(strobes - s0), 30);
        check("rand_bad_addr", 32'(bad_addr - b0), 0);
        for (int i = 0; i < 15; i++)
            check($sformatf("rand%0d", i), 32'({mem[31 + 2 * i], mem[30 + 2 * i]}),
                  32'(ref_enc({srcb[2 * i + 1][2:0], srcb[2 * i]})));

        for (int i = 0; i < 15; i++) begin
            logic [15:0] f;
            logic [11:1] dd;
            logic [3:0]  s;
            logic        par;
            int          k;
            f   = {mem[31 + 2 * i], mem[30 + 2 * i]} ^ (16'h1 << $urandom_range(15, 0));
            par = ^f;
            s   = '0;
            for (int j = 1; j < 16; j++)
                if (f[j]) s ^= 4'(j);
            if (s != 0) f[s] = ~f[s];
            k = 1;
            for (int j = 1; j < 16; j++)
                if ((j & (j - 1)) != 0) begin
                    dd[k] = f[j];
                    k++;
                end
            check($sformatf("roundtrip%0d", i), 32'({par, dd}),
                  32'({1'b1, srcb[2 * i + 1][2:0], srcb[2 * i]}));
        end

        s0 = strobes;
        run(-1, cyc);
        check("restart_cycles", 32'(cyc), 60);
        check("restart_strobes", 32'(strobes - s0), 30);
        check("restart_m14", 32'({mem[59], mem[58]}), 32'(ref_enc({srcb[29][2:0], srcb[28]})));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
